// File: rtl/addr1_queue_ctrl.sv
// addr1_queue_ctrl
//   Streaming FIFO built around the 8 x 10-bit 1R1W synchronous-read address
//   RAM. A 2-entry output buffer (ob) hides the RAM's one-cycle read latency
//   so the queue sustains one item per cycle; total capacity is DEPTH+2.
//
// Ports
//   clock, reset_n          sole clock; synchronous active-low reset
//   enq_valid/ready/bits    producer handshake (enq_ready is register-derived)
//   deq_valid/ready/bits    consumer handshake, head is ob[0]
//   count                   total occupancy (RAM + in-flight read + ob)
//   mem_W0_*                RAM write port
//   mem_R0_en/addr          RAM read port
//   mem_R0_data             RAM read data, valid the cycle after mem_R0_en
module addr1_queue_ctrl #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+3)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [CW-1:0]    count,
  output logic             mem_W0_en,
  output logic [AW-1:0]    mem_W0_addr,
  output logic [WIDTH-1:0] mem_W0_data,
  output logic             mem_R0_en,
  output logic [AW-1:0]    mem_R0_addr,
  input  logic [WIDTH-1:0] mem_R0_data
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]               mcnt_q, mcnt_d;
  logic                      rd_inflight_q, rd_inflight_d;
  logic [1:0][WIDTH-1:0]     ob_q, ob_d;
  logic [1:0]                ob_cnt_q, ob_cnt_d;

  logic       enq_fire, deq_fire, bypass, wr_en, rd_issue;
  logic [1:0] ob_tail;   // ob occupancy after this cycle's pop
  logic [2:0] rd_occ;    // ob slots already spoken for after the pop

  // Handshake outputs are forced low while reset is held.
  assign enq_ready = reset_n & (mcnt_q != FULL);
  assign deq_valid = reset_n & (ob_cnt_q != 2'd0);
  assign deq_bits  = ob_q[0];
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  assign ob_tail = ob_cnt_q - {1'b0, deq_fire};
  assign rd_occ  = {1'b0, ob_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, deq_fire};

  // Bypass only when nothing older sits in the RAM or on the read bus.
  assign bypass   = enq_fire & (mcnt_q == '0) & ~rd_inflight_q & (ob_tail < 2'd2);
  assign wr_en    = enq_fire & ~bypass;
  // Issue only if the returning word is guaranteed a free ob slot.
  assign rd_issue = reset_n & (mcnt_q != '0) & (rd_occ < 3'd2);

  assign mem_W0_en   = wr_en;
  assign mem_W0_addr = wptr_q;
  assign mem_W0_data = enq_bits;
  assign mem_R0_en   = rd_issue;
  assign mem_R0_addr = rptr_q;

  assign count = reset_n ? (CW'(mcnt_q) + CW'(rd_inflight_q) + CW'(ob_cnt_q)) : '0;

  always_comb begin
    wptr_d        = wptr_q + AW'(wr_en);
    rptr_d        = rptr_q + AW'(rd_issue);
    mcnt_d        = mcnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_issue);
    rd_inflight_d = rd_issue;
    ob_d          = ob_q;
    ob_cnt_d      = ob_tail;
    if (deq_fire) ob_d[0] = ob_q[1];
    // Pop first, then the RAM word (older) or the bypass word lands at the tail.
    // The two pushes never coincide: bypass requires no read in flight.
    if (rd_inflight_q) begin
      ob_d[ob_tail[0]] = mem_R0_data;
      ob_cnt_d         = ob_tail + 2'd1;
    end else if (bypass) begin
      ob_d[ob_tail[0]] = enq_bits;
      ob_cnt_d         = ob_tail + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mcnt_q        <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mcnt_q        <= mcnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob_cnt_q      <= ob_cnt_d;
    end
  end

  // Payload storage needs no reset; ob_cnt_q qualifies it.
  always_ff @(posedge clock) ob_q <= ob_d;

endmodule

// File: tb/tb_addr1_queue_ctrl.sv
module tb_addr1_queue_ctrl;
  localparam int WIDTH = 10;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enq_valid = 1'b0;
  logic             deq_ready = 1'b0;
  logic [WIDTH-1:0] enq_bits = '0;
  logic             enq_ready, deq_valid;
  logic [WIDTH-1:0] deq_bits;
  logic [CW-1:0]    count;
  logic             mem_W0_en, mem_R0_en;
  logic [AW-1:0]    mem_W0_addr, mem_R0_addr;
  logic [WIDTH-1:0] mem_W0_data, mem_R0_data;

  addr1_queue_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr), .mem_W0_data(mem_W0_data),
    .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr), .mem_R0_data(mem_R0_data)
  );

  always #5 clock = ~clock;

  // RAM macro model: registered read; garbage on the read bus when not reading.
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (mem_W0_en) ram[mem_W0_addr] <= mem_W0_data;
    if (mem_R0_en) mem_R0_data <= ram[mem_R0_addr];
    else           mem_R0_data <= WIDTH'($urandom);
  end

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [WIDTH-1:0] refq [$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, sample just after the falling edge,
  // check against the reference queue, then account for this cycle's fires.
  task automatic step(input bit ev, input int eb, input bit dr);
    @(negedge clock);
    reset_n = 1'b1; enq_valid = ev; enq_bits = WIDTH'(eb); deq_ready = dr;
    #1;
    chk("count", int'(count), refq.size());
    if (refq.size() == 0) chk("dv_empty", int'(deq_valid), 0);
    if (refq.size() < DEPTH) chk("enq_rdy", int'(enq_ready), 1);
    if (refq.size() == DEPTH+2) chk("enq_full", int'(enq_ready), 0);
    if (mem_W0_en) begin
      chk("waddr", int'(mem_W0_addr), wr_cnt % DEPTH);
      wr_cnt++;
    end
    if (mem_R0_en) begin
      chk("raddr", int'(mem_R0_addr), rd_cnt % DEPTH);
      rd_cnt++;
    end
    if (deq_valid && dr && refq.size() > 0) begin
      chk("deq_bits", int'(deq_bits), int'(refq[0]));
      void'(refq.pop_front());
    end
    if (ev && enq_ready) refq.push_back(WIDTH'(eb));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; enq_valid = 1'b1; deq_ready = 1'b1; enq_bits = 10'h3FF;
    #1;
    chk("rst_erdy", int'(enq_ready), 0);
    chk("rst_dv",   int'(deq_valid), 0);
    chk("rst_cnt",  int'(count), 0);
    chk("rst_we",   int'(mem_W0_en), 0);
    chk("rst_re",   int'(mem_R0_en), 0);
    refq.delete(); wr_cnt = 0; rd_cnt = 0;
  endtask

  task automatic fill_drain(input int n, input int base);
    for (int k = 0; k < n; k++) step(1'b1, base + k, 1'b0);
    for (int k = 0; k < n + 2; k++) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("fd_empty", int'(count), 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    do_reset();

    // Single item on an empty queue takes the bypass path.
    step(1'b1, 'h155, 1'b1);
    chk("t1_we",  int'(mem_W0_en), 0);
    chk("t1_dv0", int'(deq_valid), 0);
    step(1'b0, 0, 1'b1);
    chk("t1_dv",   int'(deq_valid), 1);
    chk("t1_bits", int'(deq_bits), 'h155);
    chk("t1_cnt",  int'(count), 1);
    step(1'b0, 0, 1'b0);
    chk("t1_cnt2", int'(count), 0);

    // Fill to capacity with the consumer stalled.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, k + 1, 1'b0);
      chk("fill_we", int'(mem_W0_en), (k >= 2) ? 1 : 0);
      if (k >= 2) chk("fill_wa", int'(mem_W0_addr), k - 2);
    end
    step(1'b0, 0, 1'b0);
    chk("full_rdy", int'(enq_ready), 0);
    chk("full_cnt", int'(count), 10);
    for (int d = 0; d < 10; d++) begin
      step(1'b0, 0, 1'b1);
      chk("drain_dv",   int'(deq_valid), 1);
      chk("drain_bits", int'(deq_bits), d + 1);
      if (d == 1) chk("rdy_back", int'(enq_ready), 1);
    end
    step(1'b0, 0, 1'b0);
    chk("drain_dv0", int'(deq_valid), 0);

    // Wrap-around: offset pointers by 3, then three full RAM passes.
    fill_drain(5, 'h080);
    for (int p = 0; p < 3; p++) fill_drain(10, 'h100 + p * 'h20);

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 'h200 + i, 1'b1);
      if (i >= 1) chk("stream_dv", int'(deq_valid), 1);
      chk("stream_cnt", (count <= 3) ? 1 : 0, 1);
    end
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 14; i++) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("rand_empty", int'(count), 0);

    // Reset while a read is in flight with six items held.
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 'h100 + k, 1'b0);
    step(1'b1, 'h1F0, 1'b1);
    @(negedge clock);
    enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    chk("pre_rst_cnt", int'(count), 6);
    reset_n = 1'b0; enq_valid = 1'b1; deq_ready = 1'b1;
    #1;
    chk("mid_rst_cnt", int'(count), 0);
    chk("mid_rst_dv",  int'(deq_valid), 0);
    chk("mid_rst_re",  int'(mem_R0_en), 0);
    refq.delete(); wr_cnt = 0; rd_cnt = 0;
    step(1'b0, 0, 1'b0);
    chk("post_rst_cnt", int'(count), 0);
    chk("post_rst_dv",  int'(deq_valid), 0);
    step(1'b1, 'h2AA, 1'b1);
    chk("b2aa_we", int'(mem_W0_en), 0);
    step(1'b0, 0, 1'b1);
    chk("b2aa_dv",   int'(deq_valid), 1);
    chk("b2aa_bits", int'(deq_bits), 'h2AA);
    step(1'b0, 0, 1'b0);
    chk("b2aa_cnt", int'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
